// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM states, hazard causes
// and the control-output bundles each cause produces.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_MEM     = 2'd1,
    CAUSE_BRANCH  = 2'd2,
    CAUSE_LOADUSE = 2'd3
  } cause_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_hold;
    logic ifid_flush;
    logic idex_bubble;
    logic core_freeze;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{pc_write: 1'b0, ifid_hold: 1'b0, ifid_flush: 1'b1,
                                   idex_bubble: 1'b1, core_freeze: 1'b0};
  localparam ctrl_t CTRL_IDLE = '{pc_write: 1'b1, ifid_hold: 1'b0, ifid_flush: 1'b0,
                                  idex_bubble: 1'b0, core_freeze: 1'b0};
  localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, ifid_hold: 1'b1, ifid_flush: 1'b0,
                                    idex_bubble: 1'b0, core_freeze: 1'b1};
  localparam ctrl_t CTRL_BRANCH = '{pc_write: 1'b1, ifid_hold: 1'b0, ifid_flush: 1'b1,
                                    idex_bubble: 1'b1, core_freeze: 1'b0};
  localparam ctrl_t CTRL_LOADUSE = '{pc_write: 1'b0, ifid_hold: 1'b1, ifid_flush: 1'b0,
                                     idex_bubble: 1'b1, core_freeze: 1'b0};
  localparam ctrl_t CTRL_FLUSH = '{pc_write: 1'b1, ifid_hold: 1'b0, ifid_flush: 1'b1,
                                   idex_bubble: 1'b0, core_freeze: 1'b0};

  // Fixed arbitration order: memory wait beats branch beats load-use.
  function automatic cause_e run_cause(input logic busy, input logic br, input logic lu);
    if (busy)    return CAUSE_MEM;
    else if (br) return CAUSE_BRANCH;
    else if (lu) return CAUSE_LOADUSE;
    else         return CAUSE_NONE;
  endfunction

  function automatic ctrl_t cause_ctrl(input cause_e c);
    case (c)
      CAUSE_MEM:     return CTRL_FREEZE;
      CAUSE_BRANCH:  return CTRL_BRANCH;
      CAUSE_LOADUSE: return CTRL_LOADUSE;
      default:       return CTRL_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Flags an ID-stage instruction that reads the destination of a load in EX.
module load_use_detect #(
  parameter int REG_AW = 5
) (
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              idex_memread_i,
  input  logic [REG_AW-1:0] idex_rd_i,
  output logic              hit_o
);

  logic rd_nonzero;
  logic rs_match;

  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign rd_nonzero = |idex_rd_i;
  assign rs_match   = (idex_rd_i == id_rs1_i) || (idex_rd_i == id_rs2_i);
  assign hit_o      = id_valid_i && idex_memread_i && rd_nonzero && rs_match;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: arbitrates memory wait,
// taken branch and load-use hazards, and keeps saturating statistics.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 64,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              idex_memread,
  input  logic [REG_AW-1:0] idex_rd,
  input  logic              ex_branch_taken,
  input  logic              dmem_busy,
  output logic              pc_write,
  output logic              ifid_hold,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              core_freeze,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic              err_timeout
);

  localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
  localparam logic [3:0]        FL_INIT  = 4'(FLUSH_CYCLES - 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [3:0]        fl_cnt_q, fl_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              err_q, err_d;
  logic              lu_hit;
  cause_e            cause;
  ctrl_t             ctrl;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [WAIT_W-1:0] wait_inc(input logic [WAIT_W-1:0] v);
    return (v >= WAIT_MAX) ? v : v + 1'b1;
  endfunction

  load_use_detect #(
    .REG_AW(REG_AW)
  ) u_lu (
    .id_valid_i     (id_valid),
    .id_rs1_i       (id_rs1),
    .id_rs2_i       (id_rs2),
    .idex_memread_i (idex_memread),
    .idex_rd_i      (idex_rd),
    .hit_o          (lu_hit)
  );

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = dmem_busy ? wait_inc(wait_cnt_q) : '0;
    fl_cnt_d    = fl_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    err_d       = err_q;
    cause       = CAUSE_NONE;
    ctrl        = CTRL_IDLE;

    if (reset) begin
      ctrl        = CTRL_RESET;
      state_d     = RUN;
      wait_cnt_d  = '0;
      fl_cnt_d    = '0;
      stall_cnt_d = '0;
      flush_cnt_d = '0;
      err_d       = 1'b0;
    end else begin
      case (state_q)
        FLUSH: begin
          // A branch in EX is ignored here: EX holds the bubble we inserted.
          if (dmem_busy) begin
            ctrl        = CTRL_FREEZE;
            stall_cnt_d = sat_inc(stall_cnt_q);
          end else begin
            ctrl     = CTRL_FLUSH;
            fl_cnt_d = fl_cnt_q - 4'd1;
            if (fl_cnt_q <= 4'd1) state_d = RUN;
          end
        end
        default: begin
          // MEM_WAIT with memory ready behaves exactly like RUN.
          cause = run_cause(dmem_busy, ex_branch_taken, lu_hit);
          ctrl  = cause_ctrl(cause);
          case (cause)
            CAUSE_MEM: begin
              state_d     = MEM_WAIT;
              stall_cnt_d = sat_inc(stall_cnt_q);
              if (state_q != MEM_WAIT) wait_cnt_d = WAIT_W'(1);
            end
            CAUSE_BRANCH: begin
              flush_cnt_d = sat_inc(flush_cnt_q);
              if (FLUSH_CYCLES > 1) begin
                state_d  = FLUSH;
                fl_cnt_d = FL_INIT;
              end else begin
                state_d = RUN;
              end
            end
            CAUSE_LOADUSE: begin
              stall_cnt_d = sat_inc(stall_cnt_q);
              state_d     = RUN;
            end
            default: state_d = RUN;
          endcase
        end
      endcase
      if (dmem_busy && (wait_cnt_d >= WAIT_MAX)) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    wait_cnt_q  <= wait_cnt_d;
    fl_cnt_q    <= fl_cnt_d;
    stall_cnt_q <= stall_cnt_d;
    flush_cnt_q <= flush_cnt_d;
    err_q       <= err_d;
  end

  assign pc_write    = ctrl.pc_write;
  assign ifid_hold   = ctrl.ifid_hold;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_bubble = ctrl.idex_bubble;
  assign core_freeze = ctrl.core_freeze;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed hazard scenarios plus
// randomized traffic compared against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int FC   = 2;
  localparam int TO   = 4;
  localparam int CW   = 3;
  localparam int CMAX = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid;
  logic [4:0]    id_rs1, id_rs2, idex_rd;
  logic          idex_memread, ex_branch_taken, dmem_busy;
  logic          pc_write, ifid_hold, ifid_flush, idex_bubble, core_freeze;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic          err_timeout;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .REG_AW(5), .FLUSH_CYCLES(FC), .MEM_TIMEOUT(TO), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .idex_memread(idex_memread), .idex_rd(idex_rd), .ex_branch_taken(ex_branch_taken),
    .dmem_busy(dmem_busy), .pc_write(pc_write), .ifid_hold(ifid_hold),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .core_freeze(core_freeze),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .err_timeout(err_timeout)
  );

  typedef struct {
    int       cyc;
    logic [4:0] ctl;  // {pc_write, ifid_hold, ifid_flush, idex_bubble, core_freeze}
    int       sc;
    int       fc;
    logic     err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Model: counts of remaining flush cycles and consecutive busy cycles.
  int   m_stall = 0, m_flush = 0, m_left = 0, m_run = 0;
  logic m_err = 1'b0;

  task automatic step(input logic rst, input logic v, input logic [4:0] r1,
                      input logic [4:0] r2, input logic mr, input logic [4:0] rd,
                      input logic br, input logic busy);
    exp_t e;
    logic lu;
    @(negedge clk);
    reset = rst; id_valid = v; id_rs1 = r1; id_rs2 = r2;
    idex_memread = mr; idex_rd = rd; ex_branch_taken = br; dmem_busy = busy;
    lu = v && mr && (rd != 5'd0) && (rd == r1 || rd == r2);
    e.cyc = cyc; e.sc = m_stall; e.fc = m_flush; e.err = m_err;
    if (rst) begin
      e.ctl = 5'b00110;
      m_stall = 0; m_flush = 0; m_left = 0; m_run = 0; m_err = 1'b0;
    end else if (busy) begin
      e.ctl = 5'b01001;
      m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      m_run++;
      if (m_run >= TO) m_err = 1'b1;
    end else begin
      m_run = 0;
      if (m_left > 0) begin
        e.ctl = 5'b10100;
        m_left--;
      end else if (br) begin
        e.ctl = 5'b10110;
        m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
        m_left = FC - 1;
      end else if (lu) begin
        e.ctl = 5'b01010;
        m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      end else begin
        e.ctl = 5'b10000;
      end
    end
    exp_q.push_back(e);
    cyc++;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    logic [4:0] act_ctl;
    logic [2*CW:0] act_cnt, exp_cnt;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act_ctl = {pc_write, ifid_hold, ifid_flush, idex_bubble, core_freeze};
        checks++;
        if (act_ctl !== e.ctl) begin
          errors++;
          $display("FAIL ctrl cyc=%0d got=%05b expected=%05b", e.cyc, act_ctl, e.ctl);
        end
        act_cnt = {stall_cnt, flush_cnt, err_timeout};
        exp_cnt = {CW'(e.sc), CW'(e.fc), e.err};
        checks++;
        if (act_cnt !== exp_cnt) begin
          errors++;
          $display("FAIL stats cyc=%0d got stall=%0d flush=%0d err=%0b expected stall=%0d flush=%0d err=%0b",
                   e.cyc, stall_cnt, flush_cnt, err_timeout, e.sc, e.fc, e.err);
        end
        checks++;
        if ((ifid_hold && ifid_flush) || (ifid_hold && pc_write)) begin
          errors++;
          $display("FAIL invariant cyc=%0d got hold=%0b flush=%0b pc_write=%0b expected no hold conflict",
                   e.cyc, ifid_hold, ifid_flush, pc_write);
        end
      end
    end
  end

  initial begin : stimulus
    logic       rst, v, mr, br, busy;
    logic [4:0] r1, r2, rd;
    reset = 1'b1; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0;
    idex_memread = 1'b0; idex_rd = '0; ex_branch_taken = 1'b0; dmem_busy = 1'b0;

    step(1'b1, 0, 0, 0, 0, 0, 0, 0);
    step(1'b1, 0, 0, 0, 0, 0, 0, 0);
    idle();

    // load-use on rs2, then the bubble clears memread; rd=x0 never stalls
    step(1'b0, 1'b1, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0);
    step(1'b0, 1'b1, 5'd1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    idle();

    // taken branch: two flush cycles
    step(1'b0, 0, 0, 0, 0, 0, 1'b1, 0);
    step(1'b0, 0, 0, 0, 0, 0, 1'b1, 0);
    idle();
    idle();

    // busy with branch and load-use pending, then the branch wins
    step(1'b1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 5'd3, 5'd4, 1'b1, 5'd3, 1'b1, 1'b1);
    step(1'b0, 1'b1, 5'd3, 5'd4, 1'b1, 5'd3, 1'b1, 1'b0);
    idle();
    idle();

    // timeout after four busy cycles, sticky until reset
    step(1'b1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1'b0, 0, 0, 0, 0, 0, 0, 1'b1);
    idle();
    idle();
    step(1'b1, 0, 0, 0, 0, 0, 0, 0);
    idle();

    // reset arrives during the second flush cycle
    step(1'b0, 0, 0, 0, 0, 0, 1'b1, 0);
    step(1'b1, 0, 0, 0, 0, 0, 0, 0);
    idle();
    idle();

    // saturation of the stall counter
    step(1'b1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 5'd7, 5'd2, 1'b1, 5'd7, 1'b0, 1'b0);
    idle();
    step(1'b1, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(0, 59) == 0);
      v    = 1'($urandom_range(0, 1));
      r1   = 5'($urandom_range(0, 3));
      r2   = 5'($urandom_range(0, 3));
      mr   = 1'($urandom_range(0, 1));
      rd   = 5'($urandom_range(0, 3));
      br   = ($urandom_range(0, 5) == 0);
      busy = ($urandom_range(0, 9) < 4);
      step(rst, v, r1, r2, mr, rd, br, busy);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #5;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain got pending=%0d expected pending=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline. It drives the IF/ID register's hold and flush inputs, the PC write enable, ID/EX bubble insertion and a whole-core freeze. It arbitrates three hazard sources: data-memory wait, taken branch and load-use. It also keeps saturating stall/flush statistics and a sticky memory-timeout error.

Parameters:
REG_AW, 5, register address width
FLUSH_CYCLES, 1, cycles IF/ID is flushed per taken branch (1..15; fetch latency)
MEM_TIMEOUT, 64, max consecutive dmem_busy cycles before err_timeout
CNT_W, 32, statistics counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
id_valid  in  1  ID stage holds a real instruction
id_rs1  in  REG_AW  ID source register 1
id_rs2  in  REG_AW  ID source register 2
idex_memread  in  1  instruction in EX is a load
idex_rd  in  REG_AW  destination of instruction in EX
ex_branch_taken  in  1  branch/jump in EX resolved taken
dmem_busy  in  1  data memory not ready this cycle
pc_write  out  1  1 = PC updates at next edge
ifid_hold  out  1  1 = IF/ID keeps contents (write-inhibit, active-high)
ifid_flush  out  1  1 = IF/ID loads zeros
idex_bubble  out  1  1 = ID/EX loads a NOP
core_freeze  out  1  1 = ID/EX, EX/MEM, MEM/WB hold
stall_cnt  out  CNT_W  load-use + memory stall cycles, saturating
flush_cnt  out  CNT_W  taken-branch events, saturating
err_timeout  out  1  sticky, dmem_busy exceeded MEM_TIMEOUT

Behaviour:
- Control outputs are combinational from current state + inputs. They take effect at the edge ending the current cycle. Counters, state and err_timeout are registered.
- While reset=1: pc_write=0, ifid_hold=0, ifid_flush=1, idex_bubble=1, core_freeze=0. At the edge: state<=RUN, counters<=0, err_timeout<=0, wait/flush counters<=0. Reset mid-operation aborts any wait/flush.
- Load-use hit = id_valid & idex_memread & (idex_rd!=0) & (idex_rd==id_rs1 | idex_rd==id_rs2).
- Priority per cycle: dmem_busy > ex_branch_taken > load-use. The default (no event) is pc_write=1 with all others 0.
- States: RUN, MEM_WAIT, FLUSH.
- RUN, dmem_busy: pc_write=0, ifid_hold=1, core_freeze=1, idex_bubble=0, ifid_flush=0. Next state MEM_WAIT, wait_cnt<=1, stall_cnt+1.
- RUN, branch taken (no busy): pc_write=1, ifid_flush=1, idex_bubble=1, flush_cnt+1. If FLUSH_CYCLES>1, go to FLUSH with fl_cnt<=FLUSH_CYCLES-1; else stay in RUN.
- RUN, load-use (no busy/branch): pc_write=0, ifid_hold=1, idex_bubble=1, stall_cnt+1. Stay in RUN; this yields exactly one bubble because the bubble clears idex_memread.
- MEM_WAIT, dmem_busy=1: same outputs as the RUN dmem_busy case, wait_cnt+1, stall_cnt+1. When wait_cnt reaches MEM_TIMEOUT, set err_timeout (sticky until reset); the freeze continues.
- MEM_WAIT, dmem_busy=0: outputs evaluated exactly as in RUN (branch/load-use still apply that cycle), then the normal RUN transition is taken.
- FLUSH: pc_write=1, ifid_flush=1, idex_bubble=0, fl_cnt-1. Return to RUN when fl_cnt==1. ex_branch_taken is ignored (EX holds a bubble).
- FLUSH with dmem_busy=1: freeze outputs, fl_cnt paused, state kept, stall_cnt+1.
- Output invariants: ifid_hold and ifid_flush are never both 1; pc_write=0 whenever ifid_hold=1.
- Counters saturate at all-ones and do not wrap.

Decomposition:
- pipe_ctrl_pkg: state enum {RUN, MEM_WAIT, FLUSH}, cause enum {NONE, MEM, BRANCH, LOADUSE}, reset output constants.
- Sub-module load_use_detect: combinational comparator producing the hit signal.

Test Plan:
- Load x5 in EX, ID uses rs2=x5 -> one cycle with pc_write=0, ifid_hold=1, idex_bubble=1; stall_cnt=1. Same with idex_rd=0 -> no stall.
- ex_branch_taken pulse, FLUSH_CYCLES=2 -> ifid_flush=1 for 2 consecutive cycles, idex_bubble=1 only in the first, pc_write=1 in both; flush_cnt=1.
- dmem_busy for 3 cycles with load-use and branch also asserted -> core_freeze=1 for 3 cycles, then the branch flush in cycle 4; stall_cnt=3, flush_cnt=1.
- MEM_TIMEOUT=4, dmem_busy held 6 cycles -> err_timeout rises after the 4th busy cycle and stays 1 after busy drops; cleared only by reset.
- Reset asserted mid-FLUSH (fl_cnt=1) -> reset outputs during reset; the first cycle after reset is RUN with pc_write=1 and counters=0.
- CNT_W=3, 9 load-use stalls -> stall_cnt saturates at 7.
